// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Package     : systolic_pkg
// Description : Shared types and constants for the output-stationary
//               systolic matrix engine: FSM state encoding, default widths
//               and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Engine control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int c_DEF_ROWS       = 4;
  localparam int c_DEF_COLS       = 4;
  localparam int c_DEF_DATA_WIDTH = 16;
  localparam int c_DEF_SUM_WIDTH  = 40;
  localparam int c_DEF_K_WIDTH    = 10;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_os_pe.sv
`default_nettype none
// ============================================================================
// Module      : systolic_os_pe
// Description : One output-stationary MAC processing element. On advance it
//               accumulates the full-width signed product of its operands
//               and forwards A to the right and B downward by one register.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_os_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int SUM_WIDTH  = c_DEF_SUM_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         advance_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] a_o,
  output logic signed [DATA_WIDTH-1:0] b_o,
  output logic signed [SUM_WIDTH-1:0]  acc_o
);

  logic signed [DATA_WIDTH-1:0]   a_q;
  logic signed [DATA_WIDTH-1:0]   b_q;
  logic signed [SUM_WIDTH-1:0]    acc_q;
  logic signed [SUM_WIDTH-1:0]    acc_d;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [SUM_WIDTH-1:0]    w_prod_ext;

  // Full-precision product, sign-extended, added modulo 2^SUM_WIDTH.
  always_comb begin
    w_prod     = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
    w_prod_ext = SUM_WIDTH'(w_prod);
    acc_d      = acc_q + w_prod_ext;
  end

  // Operand pass-through and accumulator; everything holds unless advanced.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (advance_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/systolic_os_engine.sv
`default_nettype none
// ============================================================================
// Module      : systolic_os_engine
// Description : ROWS x COLS output-stationary systolic matrix multiplier.
//               Operand slices are skewed into the array one beat per
//               advance, the array is flushed with zeros, then the result
//               rows are drained over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_os_engine
  import systolic_pkg::*;
#(
  parameter int ROWS       = c_DEF_ROWS,
  parameter int COLS       = c_DEF_COLS,
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int SUM_WIDTH  = c_DEF_SUM_WIDTH,
  parameter int K_WIDTH    = c_DEF_K_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [K_WIDTH-1:0]             k_len,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]     a_vec,
  input  logic [COLS*DATA_WIDTH-1:0]     b_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLS*SUM_WIDTH-1:0]      out_row,
  output logic [idx_width(ROWS)-1:0]     out_idx,
  output logic                           done
);

  localparam int c_IDX_W        = idx_width(ROWS);
  localparam int c_FLUSH_CYCLES = ROWS + COLS - 2;
  localparam int c_FLUSH_W      = idx_width(ROWS + COLS);
  localparam logic [c_IDX_W-1:0]   c_LAST_ROW   = c_IDX_W'(ROWS - 1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST =
      c_FLUSH_W'((c_FLUSH_CYCLES > 0) ? (c_FLUSH_CYCLES - 1) : 0);

  state_e               state_q;
  state_e               state_d;
  logic [K_WIDTH-1:0]   k_len_q;
  logic [K_WIDTH-1:0]   beat_cnt_q;
  logic [c_FLUSH_W-1:0] flush_cnt_q;
  logic [c_IDX_W-1:0]   out_idx_q;
  logic                 done_q;

  logic w_accept;
  logic w_advance;
  logic w_clear;
  logic w_last_beat;
  logic w_out_fire;
  logic w_last_row;

  logic signed [DATA_WIDTH-1:0] w_a_skew [ROWS];
  logic signed [DATA_WIDTH-1:0] w_b_skew [COLS];
  logic signed [DATA_WIDTH-1:0] w_pe_a   [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] w_pe_b   [ROWS][COLS];
  logic signed [SUM_WIDTH-1:0]  w_acc    [ROWS][COLS];

  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (beat_cnt_q == (k_len_q - K_WIDTH'(1)));
  assign w_out_fire  = out_valid && out_ready;
  assign w_last_row  = (out_idx_q == c_LAST_ROW);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-length flush goes straight to DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED: begin
        if (w_accept && w_last_beat) begin
          state_d = (c_FLUSH_CYCLES == 0) ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_FLUSH: if (flush_cnt_q == c_FLUSH_LAST) state_d = ST_DRAIN;
      ST_DRAIN: if (w_out_fire && w_last_row) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs and array controls.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    in_ready  = (state_q == ST_FEED);
    out_valid = (state_q == ST_DRAIN);
    w_clear   = (state_q == ST_CLEAR);
    w_advance = ((state_q == ST_FEED) && in_valid) || (state_q == ST_FLUSH);
  end

  // Job length capture, beat/flush/row counters and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DRAIN) && w_out_fire && w_last_row;
      case (state_q)
        ST_IDLE: begin
          if (start) k_len_q <= (k_len == '0) ? K_WIDTH'(1) : k_len;
        end
        ST_CLEAR: begin
          beat_cnt_q  <= '0;
          flush_cnt_q <= '0;
          out_idx_q   <= '0;
        end
        ST_FEED:  if (w_accept) beat_cnt_q <= beat_cnt_q + K_WIDTH'(1);
        ST_FLUSH: flush_cnt_q <= flush_cnt_q + c_FLUSH_W'(1);
        ST_DRAIN: begin
          if (w_out_fire) out_idx_q <= w_last_row ? '0 : out_idx_q + c_IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign done    = done_q;
  assign out_idx = out_idx_q;

  // A lane r enters the array after r advance steps; zeros outside FEED.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [DATA_WIDTH-1:0] w_lane;
    assign w_lane = (state_q == ST_FEED) ? a_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign w_a_skew[r] = w_lane;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] sr_q [r];
      // Skew shift register, stepping only on array advance.
      always_ff @(posedge clk) begin
        if (rst || w_clear) begin
          for (int j = 0; j < r; j++) sr_q[j] <= '0;
        end else if (w_advance) begin
          sr_q[0] <= w_lane;
          for (int j = 1; j < r; j++) sr_q[j] <= sr_q[j-1];
        end
      end
      assign w_a_skew[r] = sr_q[r-1];
    end
  end

  // B lane c enters the array after c advance steps; zeros outside FEED.
  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [DATA_WIDTH-1:0] w_lane;
    assign w_lane = (state_q == ST_FEED) ? b_vec[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign w_b_skew[c] = w_lane;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] sr_q [c];
      // Skew shift register, stepping only on array advance.
      always_ff @(posedge clk) begin
        if (rst || w_clear) begin
          for (int j = 0; j < c; j++) sr_q[j] <= '0;
        end else if (w_advance) begin
          sr_q[0] <= w_lane;
          for (int j = 1; j < c; j++) sr_q[j] <= sr_q[j-1];
        end
      end
      assign w_b_skew[c] = sr_q[c-1];
    end
  end

  // PE grid: A flows right along rows, B flows down columns.
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      logic signed [DATA_WIDTH-1:0] w_a_in;
      logic signed [DATA_WIDTH-1:0] w_b_in;
      if (c == 0) begin : g_a_edge
        assign w_a_in = w_a_skew[r];
      end else begin : g_a_chain
        assign w_a_in = w_pe_a[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign w_b_in = w_b_skew[c];
      end else begin : g_b_chain
        assign w_b_in = w_pe_b[r-1][c];
      end
      systolic_os_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_WIDTH)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_clear),
        .advance_i (w_advance),
        .a_i       (w_a_in),
        .b_i       (w_b_in),
        .a_o       (w_pe_a[r][c]),
        .b_o       (w_pe_b[r][c]),
        .acc_o     (w_acc[r][c])
      );
    end
  end

  // Operands leaving the far edges of the grid have no consumer.
  logic w_unused_edge;
  always_comb begin
    w_unused_edge = 1'b0;
    for (int r = 0; r < ROWS; r++) w_unused_edge = w_unused_edge ^ (^w_pe_a[r][COLS-1]);
    for (int c = 0; c < COLS; c++) w_unused_edge = w_unused_edge ^ (^w_pe_b[ROWS-1][c]);
  end

  // Result row mux; zero whenever no row is being offered.
  always_comb begin
    out_row = '0;
    if (state_q == ST_DRAIN) begin
      for (int c = 0; c < COLS; c++) out_row[c*SUM_WIDTH +: SUM_WIDTH] = w_acc[out_idx_q][c];
    end
  end

endmodule
`default_nettype wire
